// File: rtl/alu_vectorial_pkg.sv
// Shared constants for the vector ALU: operation codes and the depth of the
// result history.
package alu_vectorial_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int HIST_DEPTH = 8;

endpackage

// File: rtl/alu_vectorial_lane.sv
// One WIDTH-bit ALU lane: bitwise ops plus an adder with carry-in/carry-out.
// Subtraction is handled here by inverting B; the caller supplies carry-in 1.
module alu_lane
    import alu_vectorial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_res,
    output logic             o_cout
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;

    assign w_b_eff = (i_op == OP_SUB) ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_cin};
    assign o_cout  = w_sum[WIDTH];

    // Shift codes fall through to the sum; the top level overrides them.
    always_comb begin
        o_res = w_sum[WIDTH-1:0];
        case (i_op)
            OP_AND:  o_res = i_a & i_b;
            OP_OR:   o_res = i_a | i_b;
            OP_XOR:  o_res = i_a ^ i_b;
            OP_NOT:  o_res = ~i_a;
            default: o_res = w_sum[WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/alu_vectorial.sv
// Vector ALU built from n_alu chained lanes, with registered carry/compare
// flags and an 8-deep shifting history of results on data_out.
module alu_vectorial
    import alu_vectorial_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int n_alu = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [WIDTH*n_alu:0]                a,
    input  logic [WIDTH*n_alu:0]                b,
    input  logic [2:0]                          select,
    output logic                                carry_out,
    output logic                                a_greater,
    output logic                                a_equal,
    output logic                                a_less,
    output logic [HIST_DEPTH*WIDTH*n_alu-1:0]   data_out
);

    localparam int N = WIDTH * n_alu;

    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic         w_unused_b_msb;
    logic [n_alu:0] w_carry;
    logic [N-1:0] w_lane_res;
    logic [N-1:0] w_result;
    logic         w_cout;

    logic [N-1:0] r_hist [HIST_DEPTH];
    logic         r_carry;
    logic         r_greater;
    logic         r_equal;
    logic         r_less;

    assign w_a            = a[N-1:0];
    assign w_b            = b[N-1:0];
    assign w_unused_b_msb = b[N];

    // Subtraction is A + ~B + 1, so the chain is seeded with 1 instead of a[N].
    assign w_carry[0] = (select == OP_SUB) ? 1'b1 : a[N];

    generate
        for (genvar gi = 0; gi < n_alu; gi++) begin : g_lane
            alu_lane #(
                .WIDTH (WIDTH)
            ) u_lane (
                .i_a    (w_a[WIDTH*gi +: WIDTH]),
                .i_b    (w_b[WIDTH*gi +: WIDTH]),
                .i_cin  (w_carry[gi]),
                .i_op   (select),
                .o_res  (w_lane_res[WIDTH*gi +: WIDTH]),
                .o_cout (w_carry[gi+1])
            );
        end
    endgenerate

    always_comb begin
        w_result = w_lane_res;
        w_cout   = 1'b0;
        case (select)
            OP_ADD, OP_SUB: w_cout = w_carry[n_alu];
            OP_SHL: begin
                w_result = {w_a[N-2:0], a[N]};
                w_cout   = w_a[N-1];
            end
            OP_SHR: begin
                w_result = {a[N], w_a[N-1:1]};
                w_cout   = w_a[0];
            end
            default: w_cout = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < HIST_DEPTH; k++) begin
                r_hist[k] <= '0;
            end
            r_carry   <= 1'b0;
            r_greater <= 1'b0;
            r_equal   <= 1'b0;
            r_less    <= 1'b0;
        end else begin
            for (int k = HIST_DEPTH - 1; k > 0; k--) begin
                r_hist[k] <= r_hist[k-1];
            end
            r_hist[0] <= w_result;
            r_carry   <= w_cout;
            r_greater <= (w_a > w_b);
            r_equal   <= (w_a == w_b);
            r_less    <= (w_a < w_b);
        end
    end

    assign carry_out = r_carry;
    assign a_greater = r_greater;
    assign a_equal   = r_equal;
    assign a_less    = r_less;

    generate
        for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_out
            assign data_out[N*gi +: N] = r_hist[gi];
        end
    endgenerate

endmodule

// File: tb/tb_alu_vectorial.sv
// Self-checking bench for alu_vectorial (WIDTH=4, n_alu=4) against an
// arithmetic reference model with a queue-based result history.
module tb_alu_vectorial;

    localparam logic [2:0] S_ADD = 3'd0, S_SUB = 3'd1, S_AND = 3'd2, S_OR = 3'd3,
                           S_XOR = 3'd4, S_NOT = 3'd5, S_SHL = 3'd6, S_SHR = 3'd7;

    logic         clk;
    logic         rst;
    logic [16:0]  a;
    logic [16:0]  b;
    logic [2:0]   select;
    logic         carry_out;
    logic         a_greater;
    logic         a_equal;
    logic         a_less;
    logic [127:0] data_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic        exp_c;
    logic [2:0]  exp_flags;

    alu_vectorial #(
        .WIDTH (4),
        .n_alu (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .select    (select),
        .carry_out (carry_out),
        .a_greater (a_greater),
        .a_equal   (a_equal),
        .a_less    (a_less),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: results computed with plain integer arithmetic modulo 2^16.
    task automatic model_op(input logic [2:0] sel, input logic [16:0] av,
                            input logic [16:0] bv, output logic [15:0] r,
                            output logic c);
        int unsigned ua, ub, cin, s;
        ua  = av[15:0];
        ub  = bv[15:0];
        cin = av[16];
        s   = 0;
        c   = 1'b0;
        case (sel)
            S_ADD: begin s = ua + ub + cin; c = (s >= 65536); end
            S_SUB: begin s = (ua + 65536 - ub) % 65536; c = (ua >= ub); end
            S_AND: s = ua & ub;
            S_OR:  s = ua | ub;
            S_XOR: s = ua ^ ub;
            S_NOT: s = 65535 - ua;
            S_SHL: begin s = ua * 2 + cin; c = (ua >= 32768); end
            S_SHR: begin s = ua / 2 + cin * 32768; c = (ua % 2 == 1); end
            default: s = 0;
        endcase
        r = 16'(s % 65536);
    endtask

    function automatic logic [127:0] exp_vec();
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < exp_q.size(); k++) v[16*k +: 16] = exp_q[k];
        return v;
    endfunction

    // Drive one operation, let it pass one rising edge, advance the model.
    task automatic step(input logic [2:0] sel, input logic [16:0] av, input logic [16:0] bv);
        logic [15:0] r;
        logic        c;
        a = av;
        b = bv;
        select = sel;
        @(posedge clk);
        #1;
        model_op(sel, av, bv, r, c);
        exp_q.push_front(r);
        if (exp_q.size() > 8) void'(exp_q.pop_back());
        exp_c     = c;
        exp_flags = {av[15:0] > bv[15:0], av[15:0] == bv[15:0], av[15:0] < bv[15:0]};
        $display("op=%0d a=%05h b=%05h expect r=%04h c=%0b", sel, av, bv, r, c);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            a = 17'($urandom);
            b = 17'($urandom);
            select = 3'($urandom);
            #3;
            checks++;
            if ({data_out, carry_out, a_greater, a_equal, a_less} !== '0) begin
                errors++;
                $display("FAIL reset_hold data_out=%h c=%0b g=%0b e=%0b l=%0b required all 0",
                         data_out, carry_out, a_greater, a_equal, a_less);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_directed();
        step(S_ADD, 17'h0FFFF, 17'h00001);
        checks++;
        if ({data_out[15:0], carry_out, a_greater, a_equal, a_less} !== {16'h0000, 4'b1100}) begin
            errors++;
            $display("FAIL add_wrap slot0=%h c=%0b gel=%0b%0b%0b required 0000 c=1 gel=100",
                     data_out[15:0], carry_out, a_greater, a_equal, a_less);
        end
        step(S_SUB, 17'h00003, 17'h00005);
        checks++;
        if ({data_out[15:0], carry_out, a_greater, a_equal, a_less} !== {16'hFFFE, 4'b0001}) begin
            errors++;
            $display("FAIL sub_borrow slot0=%h c=%0b gel=%0b%0b%0b required fffe c=0 gel=001",
                     data_out[15:0], carry_out, a_greater, a_equal, a_less);
        end
        step(S_SUB, 17'h01234, 17'h01234);
        checks++;
        if ({data_out[15:0], carry_out, a_greater, a_equal, a_less} !== {16'h0000, 4'b1010}) begin
            errors++;
            $display("FAIL sub_equal slot0=%h c=%0b gel=%0b%0b%0b required 0000 c=1 gel=010",
                     data_out[15:0], carry_out, a_greater, a_equal, a_less);
        end
        step(S_SHL, 17'h18001, 17'h00000);
        checks++;
        if ({data_out[15:0], carry_out} !== {16'h0003, 1'b1}) begin
            errors++;
            $display("FAIL shl slot0=%h c=%0b required 0003 c=1", data_out[15:0], carry_out);
        end
        step(S_SHR, 17'h18001, 17'h00000);
        checks++;
        if ({data_out[15:0], carry_out} !== {16'hC000, 1'b1}) begin
            errors++;
            $display("FAIL shr slot0=%h c=%0b required c000 c=1", data_out[15:0], carry_out);
        end
        checks++;
        if (data_out !== exp_vec()) begin
            errors++;
            $display("FAIL directed_hist data_out=%h required %h", data_out, exp_vec());
        end
    endtask

    task automatic test_random();
        logic [16:0] av, bv;
        for (int i = 0; i < 120; i++) begin
            av = 17'($urandom);
            bv = 17'($urandom);
            if ($urandom_range(0, 3) == 0) bv = av;
            step(3'($urandom), av, bv);
            checks++;
            if (data_out !== exp_vec()) begin
                errors++;
                $display("FAIL rand_hist i=%0d data_out=%h required %h", i, data_out, exp_vec());
            end
            checks++;
            if (carry_out !== exp_c) begin
                errors++;
                $display("FAIL rand_carry i=%0d got %0b required %0b", i, carry_out, exp_c);
            end
            checks++;
            if ({a_greater, a_equal, a_less} !== exp_flags) begin
                errors++;
                $display("FAIL rand_flags i=%0d got %b required %b", i,
                         {a_greater, a_equal, a_less}, exp_flags);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 9; k++) step(S_XOR, 17'(k), 17'h00000);
        checks++;
        if (data_out[127:112] !== 16'h0002 || data_out[15:0] !== 16'h0009) begin
            errors++;
            $display("FAIL xor_hist_ends slot7=%h slot0=%h required 0002 0009",
                     data_out[127:112], data_out[15:0]);
        end
        checks++;
        if (data_out !== exp_vec()) begin
            errors++;
            $display("FAIL xor_hist data_out=%h required %h", data_out, exp_vec());
        end
    endtask

    task automatic test_reset_midstream();
        step(S_ADD, 17'h01111, 17'h02222);
        step(S_OR, 17'h0F0F0, 17'h00F0F);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({data_out, carry_out, a_greater, a_equal, a_less} !== '0) begin
            errors++;
            $display("FAIL midreset_clear data_out=%h c=%0b required all 0", data_out, carry_out);
        end
        #2;
        rst = 1'b1;
        exp_q.delete();
        step(S_AND, 17'h1ABCD, 17'h0FF00);
        checks++;
        if (data_out[127:16] !== '0 || data_out[15:0] !== 16'hAB00) begin
            errors++;
            $display("FAIL midreset_reload data_out=%h required only slot0=ab00", data_out);
        end
        checks++;
        if ({carry_out, a_greater, a_equal, a_less} !== {exp_c, exp_flags}) begin
            errors++;
            $display("FAIL midreset_flags got %b required %b",
                     {carry_out, a_greater, a_equal, a_less}, {exp_c, exp_flags});
        end
    endtask

    initial begin
        a = '0;
        b = '0;
        select = '0;
        exp_c = 1'b0;
        exp_flags = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_vectorial.md
ALU_VECTORIAL -- requirements
Module: alu_vectorial

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the bit width of one lane.
REQ-002 SHALL have parameter n_alu, default 4, giving the number of lanes; N = WIDTH*n_alu is the vector width (16 by default).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port a, input, N+1 bits: a[N-1:0] is operand A; a[N] is the carry/shift-in bit.
REQ-006 SHALL have port b, input, N+1 bits: b[N-1:0] is operand B; b[N] is reserved and ignored.
REQ-007 SHALL have port select, input, 3 bits: operation code.
REQ-008 SHALL have port carry_out, output, 1 bit: carry/borrow/shift-out of the latest operation, registered.
REQ-009 SHALL have ports a_greater, a_equal and a_less, outputs, 1 bit each: unsigned compare of a[N-1:0] against b[N-1:0], registered.
REQ-010 SHALL have port data_out, output, 8*N bits: an 8-slot result history, slot k at [N*k+N-1 : N*k].

Function
REQ-011 SHALL split a[N-1:0] and b[N-1:0] into n_alu lanes of WIDTH bits; lane i is bits [WIDTH*i+WIDTH-1 : WIDTH*i].
REQ-012 For arithmetic and shift operations, lanes SHALL be chained: the carry into lane 0 comes from a[N], and the carry into lane i comes from the carry out of lane i-1.
REQ-013 select=000 ADD: R = A + B + a[N]; carry_out = carry out of the top lane.
REQ-014 select=001 SUB: R = A + ~B + 1, with a[N] ignored; carry_out = 1 when A >= B (no borrow).
REQ-015 select=010 AND, 011 OR, 100 XOR: R is the bitwise result; carry_out = 0.
REQ-016 select=101 NOT: R = ~A; carry_out = 0.
REQ-017 select=110 SHL: R = {A[N-2:0], a[N]}; carry_out = A[N-1].
REQ-018 select=111 SHR: R = {a[N], A[N-1:1]}; carry_out = A[0].
REQ-019 Each rising clock edge SHALL shift the history: slot k+1 takes slot k for k = 0..6, slot 7's old value is discarded, and slot 0 takes R.
REQ-020 Latency SHALL be 1 cycle from the inputs to slot 0, carry_out and the compare flags; slot k holds the result from k+1 cycles earlier.
REQ-021 Exactly one of a_greater, a_equal, a_less SHALL be 1 after the first post-reset edge.
REQ-022 Arithmetic SHALL wrap modulo 2^N; there is no overflow flag.
REQ-023 There SHALL be no handshake: every edge accepts new inputs.

Reset
REQ-024 While rst=0, all of data_out, carry_out, a_greater, a_equal and a_less SHALL be forced to 0 immediately, independent of clk.
REQ-025 On rst deassertion, operation SHALL resume at the next rising edge.
REQ-026 Reset asserted mid-stream SHALL clear the whole history, with no partial retention.

Structure
REQ-027 A shared package alu_vectorial_pkg SHALL hold the op-code localparams (OP_ADD..OP_SHR) and the history depth constant (8).
REQ-028 One sub-module, alu_lane, SHALL implement a single WIDTH-bit lane (logic ops, add with carry-in/carry-out); it is instantiated n_alu times in a generate loop.
REQ-029 Shift, compare, history and output registers SHALL live in the top level.

Verification (defaults WIDTH=4, n_alu=4)
REQ-030 Hold rst=0 with random inputs toggling: all outputs SHALL be 0, including between clock edges.
REQ-031 ADD with a=0x0FFFF, b=0x00001: after 1 edge, slot0=0x0000, carry_out=1, a_greater=1.
REQ-032 SUB with a=0x00003, b=0x00005: slot0=0xFFFE, carry_out=0, a_less=1; then a=b=0x01234: slot0=0x0000, carry_out=1, a_equal=1.
REQ-033 SHL with a=0x18001 (a[16]=1, A=0x8001): slot0=0x0003, carry_out=1; then SHR with the same a: slot0=0xC000, carry_out=1.
REQ-034 Apply 9 consecutive XOR ops with results 0x0001..0x0009: data_out SHALL be slot7=0x0002 ... slot0=0x0009, and 0x0001 is dropped.
REQ-035 Assert rst for part of a cycle mid-stream: the history SHALL clear immediately, and the next edge after release SHALL load only slot0.
